cmp_share_arb: RTL
==================

Name: cmp_share_arb

Overview:
Shares one combinational comparator (CorePack::cmp_op_enum semantics: NO/EQ/NE/LT/GE/LTU/GEU) among NUM_REQ requesters, for example the branch unit and the SLT/SLTU path. It uses round-robin arbitration with valid/ready request handshakes and one registered result stage with per-requester response handshakes. The block sits in the execute stage between the issue logic and the single comparator instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
ID_W, $clog2(NUM_REQ), width of the internal winner index. Derived; not overridden.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  request i presents operands.
req_ready  out  NUM_REQ  request i is accepted this cycle.
req_a  in  NUM_REQ x data_t (64b each)  operand a per requester.
req_b  in  NUM_REQ x data_t  operand b per requester.
req_op  in  NUM_REQ x cmp_op_enum  opcode per requester.
resp_valid  out  NUM_REQ  result pending for requester i.
resp_res  out  1  compare result; meaningful only for the requester whose resp_valid is high.
resp_ready  in  NUM_REQ  requester i consumes its result.

Behaviour:
- Reset: out_valid=0, out_id=0, out_res=0, rr_ptr=0. Therefore req_ready=0 and resp_valid=0 in the first cycle after reset is released only if there are no requests. Reset mid-transaction drops any held result silently.
- Result register: {out_valid, out_id, out_res}. resp_valid[i] = out_valid && out_id==i. resp_res = out_res.
- drain = out_valid && resp_ready[out_id]. can_accept = !out_valid || drain. This gives full throughput of one compare per cycle with back-to-back draining.
- Arbitration (combinational):
  - Search starts at rr_ptr and scans ascending, wrapping at NUM_REQ-1 to 0.
  - The first i with req_valid[i] wins.
  - grant_i = win_i && can_accept. req_ready = one-hot grant; it is all-zero when nothing is valid or when !can_accept.
  - req_ready does not depend on resp_ready of non-holders.
- On grant to w at edge N:
  - out_res <= Cmp(req_a[w], req_b[w], req_op[w]).
  - out_id <= w, out_valid <= 1.
  - rr_ptr <= (w+1) mod NUM_REQ.
  - resp_valid[w] is high from cycle N+1. Latency is exactly 1 cycle.
- Drain without a new grant: out_valid <= 0, and out_id/out_res hold their values.
- No valid requests: rr_ptr is unchanged.
- Compare semantics:
  - EQ/NE use bitwise equality.
  - LT/GE use a signed 64-bit compare.
  - LTU/GEU use an unsigned compare.
  - CMP_NO, CMP7 and undefined encodings yield 0.
- Stability rules:
  - Requesters hold req_* stable while req_valid is high and req_ready is low.
  - The block holds resp_valid and resp_res stable until drained.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Simultaneous drain and grant to the same requester in one cycle is legal. The result register is overwritten and resp_valid stays high with the new value.

Optional Feature:
Macro: CMP_SHARE_ARB_PERF_EN.
- Defined:
  - Adds output perf_grant_cnt (NUM_REQ x 32b), the count of grants per requester.
  - Adds output perf_stall_cnt (NUM_REQ x 32b), the count of cycles with req_valid[i] && !req_ready[i].
  - Both counters clear on rst and wrap modulo 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Use the existing package CorePack for data_t (64b), cmp_op_enum and its encodings. No new types are added.
- Add a package constant CMP_ARB_MAX_REQ=8.
- One sub-module, rr_arbiter (NUM_REQ):
  - Inputs: req vector, rr_ptr, enable.
  - Output: one-hot grant and winner index.
  - Purely combinational.
- The existing comparator module is instantiated once on the muxed operands.

Test Plan:
1. Reset then idle:
   - Stimulus: assert rst for 2 cycles, then deassert with all req_valid=0.
   - Response: req_ready=0, resp_valid=0, rr_ptr=0.
2. Single request:
   - Stimulus: req0 with a=5, b=5, op=EQ, resp_ready=1.
   - Response: req_ready=01 in cycle N; resp_valid=01 and resp_res=1 in cycle N+1.
3. Round-robin contention:
   - Stimulus: both requesters hold valid for 4 cycles. req0 is LT with a=-1 and b=1; req1 is LTU with a=-1 and b=1. resp_ready=11 throughout.
   - Response: grants alternate 0,1,0,1. Results are 1 (signed) and 0 (unsigned).
4. Backpressure:
   - Stimulus: req1 is granted, then resp_ready[1]=0 for 3 cycles while req0 stays valid.
   - Response: req_ready=00 and resp_res is stable for those cycles. When resp_ready[1]=1, req0 is granted in that same cycle.
5. Opcode edges:
   - Stimulus: GEU with a=0 and b=0xFFFF_FFFF_FFFF_FFFF; then CMP_NO; then CMP7.
   - Response: results 0, 0, 0.
6. Reset mid-flight:
   - Stimulus: assert rst while resp_valid=10 and resp_ready=0.
   - Response: the next cycle shows resp_valid=00, rr_ptr=0, and the result is never delivered. With CMP_SHARE_ARB_PERF_EN defined, the counters read 0.

Source files
------------

// File: rtl/cmp_share_arb_pkg.sv
// ---------------------------------------------------------------------------
// cmp_share_arb_pkg: constants and helpers for the shared-comparator arbiter.
//   CMP_ARB_MAX_REQ : largest supported number of requesters.
//   rr_wrap         : index of the k-th candidate when scanning from ptr.
//   rr_next         : pointer value following winner w.
// No ports.
// ---------------------------------------------------------------------------
package cmp_share_arb_pkg;

  localparam int CMP_ARB_MAX_REQ = 8;

  // Candidate index ptr+k folded back into 0..n-1 (k < n, ptr < n).
  function automatic int rr_wrap(input int ptr, input int k, input int n);
    int sum;
    sum = ptr + k;
    if (sum >= n) begin
      rr_wrap = sum - n;
    end else begin
      rr_wrap = sum;
    end
  endfunction

  // Requester after w, wrapping at n-1 to 0.
  function automatic int rr_next(input int w, input int n);
    if (w + 1 >= n) begin
      rr_next = 0;
    end else begin
      rr_next = w + 1;
    end
  endfunction

endpackage

// File: rtl/core_pack.sv
// ---------------------------------------------------------------------------
// CorePack: core-wide shared types.
//   data_t      : 64-bit datapath word.
//   cmp_op_enum : comparator opcode (NO/EQ/NE/LT/GE/LTU/GEU, CMP7 reserved).
// No ports; imported by the execute-stage blocks.
// ---------------------------------------------------------------------------
package CorePack;

  typedef logic [63:0] data_t;

  typedef enum logic [2:0] {
    CMP_NO  = 3'd0,
    CMP_EQ  = 3'd1,
    CMP_NE  = 3'd2,
    CMP_LT  = 3'd3,
    CMP_GE  = 3'd4,
    CMP_LTU = 3'd5,
    CMP_GEU = 3'd6,
    CMP7    = 3'd7
  } cmp_op_enum;

endpackage

// File: rtl/cmp_share_arb_if.sv
// ---------------------------------------------------------------------------
// cmp_share_arb_if: request/response bundle between NUM_REQ requesters and
// the shared comparator arbiter.
//   req_valid/req_ready : per-requester request handshake.
//   req_a/req_b/req_op  : operands and opcode per requester.
//   resp_valid/resp_ready : per-requester response handshake.
//   resp_res            : single result bit, owned by the resp_valid holder.
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface cmp_share_arb_if #(
  parameter int NUM_REQ = 2
);
  import CorePack::*;

  logic       [NUM_REQ-1:0] req_valid;
  logic       [NUM_REQ-1:0] req_ready;
  data_t      [NUM_REQ-1:0] req_a;
  data_t      [NUM_REQ-1:0] req_b;
  cmp_op_enum [NUM_REQ-1:0] req_op;
  logic       [NUM_REQ-1:0] resp_valid;
  logic                     resp_res;
  logic       [NUM_REQ-1:0] resp_ready;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_res
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_res
  );

endinterface

// File: rtl/cmp_share_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick.
//   req    : request vector
//   rr_ptr : first index examined; scan ascends and wraps NUM_REQ-1 -> 0
//   enable : when low, no grant is issued (winner index is still reported)
//   grant  : one-hot grant, all-zero if nothing requests or !enable
//   win_id : index of the first requester found (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
  import cmp_share_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    win_id
);

  logic found_s;

  // Scan from rr_ptr upward; the first active request wins.
  always_comb begin
    found_s = 1'b0;
    win_id  = '0;
    grant   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && req[rr_wrap(int'(rr_ptr), k, NUM_REQ)]) begin
        found_s = 1'b1;
        win_id  = ID_W'(rr_wrap(int'(rr_ptr), k, NUM_REQ));
      end else begin
        found_s = found_s;
      end
    end
    if (enable && found_s) begin
      grant[win_id] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/comparator.sv
// ---------------------------------------------------------------------------
// comparator: single combinational 64-bit compare unit.
//   a, b : operands
//   op   : cmp_op_enum opcode
//   res  : 1 when the relation holds; 0 for CMP_NO, CMP7 and anything unknown.
// ---------------------------------------------------------------------------
module comparator
  import CorePack::*;
(
  input  data_t      a,
  input  data_t      b,
  input  cmp_op_enum op,
  output logic       res
);

  // Opcode decode into the selected relation.
  always_comb begin
    res = 1'b0;
    case (op)
      CMP_EQ:  res = (a == b);
      CMP_NE:  res = (a != b);
      CMP_LT:  res = ($signed(a) <  $signed(b));
      CMP_GE:  res = ($signed(a) >= $signed(b));
      CMP_LTU: res = (a <  b);
      CMP_GEU: res = (a >= b);
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_share_arb.sv
// ---------------------------------------------------------------------------
// cmp_share_arb: shares one comparator among NUM_REQ requesters.
// Round-robin arbitration, one registered result stage, per-requester
// response handshake. One compare per cycle when results drain back-to-back.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (drops any held result)
//   bus  : cmp_share_arb_if.slave (request and response handshakes)
//   perf_grant_cnt / perf_stall_cnt : only with CMP_SHARE_ARB_PERF_EN
//     defined; per-requester grant count and cycles spent valid-but-not-ready,
//     both wrapping modulo 2^32.
//
// Optional feature macro: CMP_SHARE_ARB_PERF_EN
// ---------------------------------------------------------------------------
module cmp_share_arb
  import CorePack::*;
  import cmp_share_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst,
  cmp_share_arb_if.slave bus
`ifdef CMP_SHARE_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0] perf_grant_cnt,
  output logic [NUM_REQ-1:0][31:0] perf_stall_cnt
`endif
);

  logic               out_valid_r;
  logic [ID_W-1:0]    out_id_r;
  logic               out_res_r;
  logic [ID_W-1:0]    rr_ptr_r;

  logic               drain_s;
  logic               can_accept_s;
  logic               any_grant_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    win_id_s;
  data_t              a_sel_s;
  data_t              b_sel_s;
  cmp_op_enum         op_sel_s;
  logic               cmp_res_s;

  // Only the current holder's resp_ready matters; others cannot stall us.
  assign drain_s      = out_valid_r & bus.resp_ready[out_id_r];
  assign can_accept_s = ~out_valid_r | drain_s;
  assign any_grant_s  = |grant_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_r),
    .enable (can_accept_s),
    .grant  (grant_s),
    .win_id (win_id_s)
  );

  assign bus.req_ready = grant_s;

  // Operands of the winner feed the single comparator instance.
  assign a_sel_s  = bus.req_a[win_id_s];
  assign b_sel_s  = bus.req_b[win_id_s];
  assign op_sel_s = bus.req_op[win_id_s];

  comparator u_cmp (
    .a   (a_sel_s),
    .b   (b_sel_s),
    .op  (op_sel_s),
    .res (cmp_res_s)
  );

  // Result register and round-robin pointer. A grant in the same cycle as a
  // drain simply overwrites the result; drain alone clears only the valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_id_r    <= '0;
      out_res_r   <= 1'b0;
      rr_ptr_r    <= '0;
    end else if (any_grant_s) begin
      out_valid_r <= 1'b1;
      out_id_r    <= win_id_s;
      out_res_r   <= cmp_res_s;
      rr_ptr_r    <= ID_W'(rr_next(int'(win_id_s), NUM_REQ));
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Response valid decoded from the held owner.
  always_comb begin
    bus.resp_valid = '0;
    if (out_valid_r) begin
      bus.resp_valid[out_id_r] = 1'b1;
    end else begin
      bus.resp_valid = '0;
    end
  end

  assign bus.resp_res = out_res_r;

`ifdef CMP_SHARE_ARB_PERF_EN
  // Per-requester grant and stall counters, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        perf_grant_cnt[i] <= perf_grant_cnt[i] + {31'd0, grant_s[i]};
        perf_stall_cnt[i] <= perf_stall_cnt[i] + {31'd0, bus.req_valid[i] & ~grant_s[i]};
      end
    end
  end
`endif

endmodule
